// File: rtl/aes_key_pkg.sv
// aes_key_pkg: key-length encoding, per-length sizing helpers and GF(2^8) doubling for the AES key schedule
package aes_key_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_RSV = 2'b11
    } key_len_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(key_len_t kl);
        return kl == KL_256 ? 4'd8 : kl == KL_192 ? 4'd6 : 4'd4;
    endfunction

    function automatic logic [3:0] nr_of(key_len_t kl);
        return nk_of(kl) + 4'd6;
    endfunction

    function automatic logic [5:0] total_words_of(key_len_t kl);
        return {nr_of(kl), 2'b00} + 6'd4;
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: applies the AES S-box to each byte of a 32-bit word, purely combinational
module aes_sub_word (
    input  logic [31:0] word,
    output logic [31:0] result
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign result[8*b +: 8] = SBOX[word[8*b +: 8]];
    end

endmodule

// File: rtl/aes_key_schedule_store.sv
// aes_key_schedule_store: word-serial AES-128/192/256 key expansion into a four-bank round-key store with random-access reads
module aes_key_schedule_store
    import aes_key_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key,
    output logic                    busy,
    output logic                    done,
    output logic                    key_ready,
    output logic [3:0]              num_rounds,
    output logic                    cfg_err,
    input  logic                    rd_en,
    input  logic [3:0]              rd_round,
    output logic [127:0]            round_key,
    output logic                    key_valid
);

    localparam int ROWS = MAX_KEY_BITS / 32 + 7;
    localparam logic [3:0] MAX_NK = 4'(MAX_KEY_BITS / 32);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    logic [0:0]              state;
    logic [5:0]              idx;
    logic [2:0]              pos;
    logic [7:0]              rcon;
    key_len_t                kl;
    key_len_t                req;
    logic [MAX_KEY_BITS-1:0] key_reg;
    logic [31:0]             win [8];
    logic [3:0]              nk;
    logic [2:0]              tap;
    logic                    in_key;
    logic                    rot;
    logic                    sub_only;
    logic                    start_bad;
    logic                    rd_ok;
    logic [31:0]             sub_src;
    logic [31:0]             sub_res;
    logic [31:0]             temp;
    logic [31:0]             w_new;
    logic [31:0]             rd_words [4];

    assign busy = state == ST_EXPAND;

    // next schedule word: key words first, then w[i-Nk] ^ transformed w[i-1]; one S-box bank serves both transforms
    always_comb begin
        req = key_len_t'(key_len);
        nk = nk_of(kl);
        tap = 3'(nk - 4'd1);
        in_key = idx < {2'b00, nk};
        rot = !in_key && pos == 3'd0;
        sub_only = !in_key && nk == 4'd8 && pos == 3'd4;
        sub_src = rot ? {win[0][23:0], win[0][31:24]} : win[0];
        temp = rot ? sub_res ^ {rcon, 24'h0} : sub_only ? sub_res : win[0];
        w_new = in_key ? key_reg[MAX_KEY_BITS-1 -: 32] : win[tap] ^ temp;
        start_bad = req == KL_RSV || nk_of(req) > MAX_NK;
        rd_ok = rd_en && key_ready && !busy && rd_round <= num_rounds;
    end

    aes_sub_word u_sub (
        .word   (sub_src),
        .result (sub_res)
    );

    // control FSM and expansion state; done/key_ready are raised one edge early so they coincide with the last write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx <= '0;
            pos <= '0;
            rcon <= RCON_INIT;
            kl <= KL_128;
            key_reg <= '0;
            for (int k = 0; k < 8; k++) win[k] <= '0;
            done <= 1'b0;
            key_ready <= 1'b0;
            num_rounds <= '0;
            cfg_err <= 1'b0;
        end else begin
            done <= 1'b0;
            cfg_err <= 1'b0;
            if (state == ST_IDLE) begin
                if (start && start_bad) begin
                    cfg_err <= 1'b1;
                end else if (start) begin
                    state <= ST_EXPAND;
                    kl <= req;
                    key_reg <= key;
                    idx <= '0;
                    pos <= '0;
                    rcon <= RCON_INIT;
                    key_ready <= 1'b0;
                end
            end else begin
                key_reg <= key_reg << 32;
                win[0] <= w_new;
                for (int k = 1; k < 8; k++) win[k] <= win[k-1];
                idx <= idx + 6'd1;
                pos <= pos == tap ? 3'd0 : pos + 3'd1;
                if (rot) rcon <= xtime(rcon);
                if (idx == total_words_of(kl) - 6'd2) begin
                    done <= 1'b1;
                    key_ready <= 1'b1;
                    num_rounds <= nr_of(kl);
                end
                if (idx == total_words_of(kl) - 6'd1) state <= ST_IDLE;
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [31:0] mem [ROWS];
        // word i lands in bank i mod 4 at row i/4, so a row across the banks is one round key
        always_ff @(posedge clk) begin
            if (busy && idx[1:0] == 2'(b)) mem[idx[5:2]] <= w_new;
        end
        assign rd_words[b] = mem[rd_round];
    end

    // registered read port; rejected reads hold the previous key
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_key <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= rd_ok;
            if (rd_ok) round_key <= {rd_words[0], rd_words[1], rd_words[2], rd_words[3]};
        end
    end

endmodule

// File: doc/aes_key_schedule_store.md
# aes_key_schedule_store

Parametrised AES key-expansion engine with an on-chip round-key store, supporting AES-128/192/256 selectable per key. The block expands a cipher key word-serially (one 32-bit word per cycle) into four word banks. It then serves any round key by index with a one-cycle registered read. Random access lets the decryption datapath walk rounds Nr→0 and the encryption datapath walk 0→Nr from the same store, replacing the forward-only, 128-bit-only, one-key-per-enable generator.

## Interface
Parameters:
- MAX_KEY_BITS, 256, largest supported key size (128, 192 or 256). Sets key port width and store depth (Nr_max+1 rows per bank).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to expand `key` under `key_len`.
- key_len  in  2  00=128, 01=192, 10=256, 11=reserved.
- key  in  MAX_KEY_BITS  cipher key, left-aligned: word 0 = key[MSB -: 32]; unused LSBs ignored.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the last word is written.
- key_ready  out  1  store holds a complete, valid schedule.
- num_rounds  out  4  Nr of the stored schedule (10/12/14).
- cfg_err  out  1  one-cycle pulse: start rejected (reserved key_len, or key_len exceeds MAX_KEY_BITS).
- rd_en  in  1  read request.
- rd_round  in  4  round index to read.
- round_key  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- key_valid  out  1  round_key updated with a valid key this cycle.

## Operation
- Nk = 4/6/8 and Nr = 10/12/14. Total words T = 4(Nr+1) = 44/52/60.
- FSM states:
  - IDLE: accepts start.
    - Valid start: latch key and key_len, i←0, rcon←01, clear key_ready, go to EXPAND.
    - Invalid start: pulse cfg_err, stay in IDLE; the old schedule and key_ready are kept.
  - EXPAND: one word w[i] per cycle.
    - i<Nk: w[i] = key word i.
    - Otherwise temp = w[i-1], then:
      - i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon←xtime(rcon).
      - Else if Nk=8 and i mod 8 = 4: temp = SubWord(temp).
      - w[i] = w[i-Nk] ^ temp.
    - w[i] is written to bank (i mod 4) at row i/4.
    - An 8-word sliding window holds w[i-1]…w[i-8]. w[i-Nk] is window tap Nk-1.
    - At i = T-1: write, pulse done, set key_ready, load num_rounds, go to IDLE.
- start while busy is ignored, with no cfg_err.
- Read path:
  - rd_en with key_ready=1 and rd_round ≤ num_rounds: next cycle round_key = stored key, key_valid=1.
  - Otherwise: key_valid=0 and round_key holds its previous value.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).

## Timing
- Reset values: busy=0, done=0, key_ready=0, num_rounds=0, cfg_err=0, round_key=0, key_valid=0, FSM=IDLE. Store contents are don't-care.
- start at cycle 0 → busy=1 from cycle 1, and words are written in cycles 1…T.
  - done and key_ready rise in cycle T: 44/52/60 for 128/192/256.
  - busy falls in cycle T+1.
- Read latency is 1 cycle. Back-to-back reads give one key per cycle.
- A read in the same cycle that done rises returns key_valid=0. The first valid read is issued with key_ready=1 visible.
- Reset asserted mid-expansion aborts immediately. key_ready stays 0 until a new expansion completes.
- A new start after completion clears key_ready in cycle 1. Reads during re-expansion return key_valid=0.

## Structure
- Package aes_key_pkg:
  - key_len encoding as a typedef.
  - Functions nk_of, nr_of and total_words_of.
  - xtime function.
  - Rcon seed constant.
- Sub-module aes_sub_word: four S-box instances on a 32-bit word, combinational. This single instance is shared by the RotWord and plain-SubWord paths via an input mux.
- Store: four 32-bit banks with (MAX_KEY_BITS/32 + 7) rows each, synchronous write, registered read.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, start:
  - done in cycle 44.
  - rd_round=0 → 2b7e151628aed2a6abf7158809cf4f3c.
  - rd_round=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done in cycle 52 and num_rounds=12.
  - rd_round=12 → e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done in cycle 60.
  - rd_round=14 → fe4890d1e6188d0b046df344706c631e.
  - rd_round=15 → key_valid=0.
- Decrypt sweep: after the AES-128 load, issue rd_round=10…0 on consecutive cycles → 11 consecutive key_valid=1 cycles with keys in descending order, matching a reference model.
- Error and hazard cases:
  - key_len=11 → cfg_err pulse, key_ready unchanged.
  - With MAX_KEY_BITS=128, key_len=10 → cfg_err pulse.
  - start during busy → ignored; the result equals the first key's schedule.
- rst low at cycle 20 of a 256-bit expansion → all outputs at reset values asynchronously. Reads return key_valid=0 until a fresh expansion completes.
